// File: rtl/aes_pkg.sv
// Shared AES definitions: state/column widths, GF(2^8) doubling and the
// control states of the iterative MixColumns stage.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // Multiply by x in GF(2^8), reduced by the AES polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns transform of one 32-bit column; byte a0 sits at
// the MSB. Shared with the inverse-cipher datapath.
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col,
  output logic [AES_COL_W-1:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign {a0, a1, a2, a3} = col;

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a is expressed as xtime(a) ^ a
  assign mixed = {x0 ^ (x1 ^ a1) ^ a2 ^ a3,
                  a0 ^ x1 ^ (x2 ^ a2) ^ a3,
                  a0 ^ a1 ^ x2 ^ (x3 ^ a3),
                  (x0 ^ a0) ^ a1 ^ a2 ^ x3};

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: transforms COLS_PER_CYCLE columns per busy
// cycle, or passes the state through untouched for the final round.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // The column counter is 2 bits wide, so a step of 4 wraps to 0.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  mc_state_e              state;
  logic [1:0]             col_cnt;
  logic [AES_STATE_W-1:0] src;
  logic [AES_STATE_W-1:0] result;

  logic [1:0]           col_idx [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] col_out [COLS_PER_CYCLE];

  always_comb begin
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      col_idx[i] = col_cnt + 2'(i);
      col_in[i]  = src[AES_STATE_W-1 - AES_COL_W*int'(col_idx[i]) -: AES_COL_W];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    aes_mix_column u_mix_column (
      .col   (col_in[g]),
      .mixed (col_out[g])
    );
  end

  assign out_state = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      col_cnt   <= 2'd0;
      src       <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            src      <= in_state;
            col_cnt  <= 2'd0;
            in_ready <= 1'b0;
            if (in_bypass) begin
              result    <= in_state;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            result[AES_STATE_W-1 - AES_COL_W*int'(col_idx[i]) -: AES_COL_W] <= col_out[i];
          end
          col_cnt <= col_cnt + COL_STEP;
          if (col_cnt == COL_LAST) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle)
// checked against a GF(2^8) matrix model plus hand-computed vectors.
module tb_mix_columns_iter;

  localparam logic [127:0] V2 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] E2 = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] V3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V4 = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         in_bypass [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];

  logic [31:0]  tc_in;
  logic [31:0]  tc_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .in_bypass (in_bypass[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  aes_mix_column u_tc (
    .col   (tc_in),
    .mixed (tc_out)
  );

  // Reference: generic GF(2^8) multiply and the MixColumns matrix product
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c);
    logic [7:0] m [4][4] = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
                             '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
    logic [7:0]  a [4];
    logic [31:0] r = '0;
    for (int j = 0; j < 4; j++) a[j] = c[31 - 8*j -: 8];
    for (int i = 0; i < 4; i++) begin
      logic [7:0] acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[i][j], a[j]);
      r[31 - 8*i -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s);
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = model_col(s[127 - 32*c -: 32]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: one outstanding transfer per instance, checked every cycle
  logic         pend [3] = '{0, 0, 0};
  logic         seen [3] = '{0, 0, 0};
  int           cnt  [3] = '{0, 0, 0};
  int           lat  [3] = '{0, 0, 0};
  logic [127:0] expq [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pend[k] = 1'b0;
        chk($sformatf("rst_out_valid%0d", k), 128'(out_valid[k]), 128'd0);
        chk($sformatf("rst_in_ready%0d", k), 128'(in_ready[k]), 128'd1);
      end else if (pend[k]) begin
        cnt[k]++;
        chk($sformatf("held_in_ready%0d", k), 128'(in_ready[k]), 128'd0);
        if (out_valid[k]) begin
          if (!seen[k]) begin
            chk($sformatf("latency%0d", k), 128'(cnt[k]), 128'(lat[k]));
            seen[k] = 1'b1;
          end
          chk($sformatf("out_state%0d", k), out_state[k], expq[k]);
          if (out_ready[k]) pend[k] = 1'b0;
        end else if (seen[k]) begin
          chk($sformatf("out_valid_drop%0d", k), 128'(out_valid[k]), 128'd1);
        end
        if (pend[k] && cnt[k] > 40) begin
          checks++;
          failures++;
          $display("FAIL timeout%0d cycles=%0d required<=40", k, cnt[k]);
          pend[k] = 1'b0;
        end
      end else begin
        chk($sformatf("idle_in_ready%0d", k), 128'(in_ready[k]), 128'd1);
        chk($sformatf("idle_out_valid%0d", k), 128'(out_valid[k]), 128'd0);
        if (in_valid[k]) begin
          pend[k] = 1'b1;
          seen[k] = 1'b0;
          cnt[k]  = 0;
          expq[k] = in_bypass[k] ? in_state[k] : model_state(in_state[k]);
          lat[k]  = in_bypass[k] ? 1 : 4 / (1 << k) + 1;
        end
      end
    end
  end

  task automatic send(input int k, input logic [127:0] st, input logic byp);
    bit ok = 0;
    in_state[k]  = st;
    in_bypass[k] = byp;
    in_valid[k]  = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (in_ready[k]) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL accept%0d in_ready=0 required=1", k);
    end
    @(posedge clk);
    #1;
    in_valid[k]  = 1'b0;
    in_state[k]  = {$urandom, $urandom, $urandom, $urandom};
    in_bypass[k] = ~byp;
  endtask

  task automatic wait_out(input int k);
    bit ok = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (out_valid[k]) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL wait_out%0d out_valid=0 required=1", k);
    end
  endtask

  initial begin
    logic [31:0] tv [5] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5};
    logic [31:0] te [5] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6};
    int waited;

    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_state[k] = '0; in_bypass[k] = 1'b0; out_ready[k] = 1'b1;
    end
    tc_in = '0;

    for (int i = 0; i < 5; i++) begin
      tc_in = tv[i];
      #1;
      chk($sformatf("column%0d", i), 128'(tc_out), 128'(te[i]));
      chk($sformatf("model_column%0d", i), 128'(model_col(tv[i])), 128'(te[i]));
    end
    chk("model_state", model_state(V2), E2);

    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_out_state%0d", k), out_state[k], 128'd0);
    #1 rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      // Full-state transform with downstream always ready
      out_ready[k] = 1'b1;
      send(k, V2, 1'b0);
      wait_out(k);
      chk($sformatf("vec2_%0d", k), out_state[k], E2);
      @(posedge clk); #1;

      // Final-round bypass
      send(k, V3, 1'b1);
      wait_out(k);
      chk($sformatf("bypass_%0d", k), out_state[k], V3);
      @(posedge clk); #1;

      // Backpressure with a second state held by the sender
      out_ready[k] = 1'b0;
      send(k, V2, 1'b0);
      wait_out(k);
      in_state[k] = V4; in_bypass[k] = 1'b0; in_valid[k] = 1'b1;
      repeat (10) begin
        @(negedge clk);
        chk($sformatf("bp_valid%0d", k), 128'(out_valid[k]), 128'd1);
        chk($sformatf("bp_state%0d", k), out_state[k], E2);
        chk($sformatf("bp_ready%0d", k), 128'(in_ready[k]), 128'd0);
      end
      @(posedge clk); #1;
      out_ready[k] = 1'b1;
      waited = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        waited++;
        if (in_ready[k]) break;
      end
      chk($sformatf("bp_accept_delay%0d", k), 128'(waited), 128'd2);
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      wait_out(k);
      chk($sformatf("bp_second%0d", k), out_state[k], model_state(V4));
      @(posedge clk); #1;

      // Asynchronous reset in the middle of an operation
      in_state[k] = V2; in_bypass[k] = 1'b0; in_valid[k] = 1'b1;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (in_ready[k]) break;
      end
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      repeat (k == 0 ? 2 : 1) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk($sformatf("arst_valid%0d", k), 128'(out_valid[k]), 128'd0);
      chk($sformatf("arst_ready%0d", k), 128'(in_ready[k]), 128'd1);
      chk($sformatf("arst_state%0d", k), out_state[k], 128'd0);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (8) @(negedge clk);
      @(posedge clk); #1;
      send(k, V2, 1'b0);
      wait_out(k);
      chk($sformatf("post_rst%0d", k), out_state[k], E2);
      @(posedge clk); #1;

      // Back-to-back states, sender holding in_valid between accepts
      for (int n = 0; n < 6; n++) send(k, {$urandom, $urandom, $urandom, $urandom}, n == 3);
      wait_out(k);
      @(posedge clk); #1;
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
